// File: rtl/mosby_pkg.sv
// Shared definitions for the writeback path: destination codes, P flag bit
// positions, the P reset value and the queued writeback entry.
package mosby_pkg;

    localparam logic [1:0] DEST_A    = 2'b00;
    localparam logic [1:0] DEST_X    = 2'b01;
    localparam logic [1:0] DEST_Y    = 2'b10;
    localparam logic [1:0] DEST_NONE = 2'b11;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_B = 4;
    localparam int FLAG_U = 5;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    localparam logic [7:0] P_RESET  = 8'h24;
    localparam logic [7:0] P_U_MASK = 8'h01 << FLAG_U;

    typedef struct packed {
        logic [1:0] dest;
        logic [7:0] mask;
        logic [7:0] result;
        logic [7:0] status;
    } wb_entry_t;

    // Masked flag update; the unused bit is pinned high.
    function automatic logic [7:0] merge_flags(input logic [7:0] p, input wb_entry_t e);
        return (p & ~e.mask) | (e.status & e.mask) | P_U_MASK;
    endfunction

endpackage

// File: rtl/wb_queue.sv
// Two-entry FIFO holding ALU results until the writeback stage commits them.
// Pushes while full and pops while empty are ignored.
module wb_queue #(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  mosby_pkg::wb_entry_t din,
    output mosby_pkg::wb_entry_t head,
    output mosby_pkg::wb_entry_t second,
    output logic [1:0]          count,
    output logic                full,
    output logic                empty
);
    import mosby_pkg::*;

    wb_entry_t mem [2];
    logic      wr_ptr;
    logic      rd_ptr;
    logic      push_ok;
    logic      pop_ok;

    assign full    = (count == 2'(DEPTH));
    assign empty   = (count == 2'd0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign second  = mem[~rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed when counted valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: queues ALU results and commits them into A/X/Y and P.
// Optional macro WB_BYPASS_EN forwards queued results to acc_out/p_out.
module reg_writeback #(
    parameter int         DEPTH   = 2,
    parameter logic [7:0] P_RESET = mosby_pkg::P_RESET
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wb_valid,
    output logic       wb_ready,
    input  logic [1:0] wb_dest,
    input  logic [7:0] wb_flag_mask,
    input  logic [7:0] alu_result,
    input  logic [7:0] alu_status,
    input  logic       hold,
    input  logic       reg_wr,
    input  logic [1:0] reg_sel,
    input  logic [7:0] reg_wdata,
    input  logic       plp_wr,
    input  logic [7:0] plp_data,
    output logic [7:0] acc_out,
    output logic [7:0] x_out,
    output logic [7:0] y_out,
    output logic [7:0] p_out,
    output logic       idle
);
    import mosby_pkg::*;

    wb_entry_t  din;
    wb_entry_t  head;
    wb_entry_t  second;
    logic [1:0] count;
    logic       full;
    logic       empty;
    logic       commit;
    logic [7:0] a_q, x_q, y_q, p_q;

    assign din    = '{dest: wb_dest, mask: wb_flag_mask, result: alu_result, status: alu_status};
    assign commit = !hold && !empty;

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk    (clk),
        .rst    (rst),
        .push   (wb_valid),
        .pop    (commit),
        .din    (din),
        .head   (head),
        .second (second),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    // Direct loads are checked first so they win over a same-register commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= 8'h00;
            x_q <= 8'h00;
            y_q <= 8'h00;
            p_q <= P_RESET | P_U_MASK;
        end else begin
            if (reg_wr && reg_sel == DEST_A)      a_q <= reg_wdata;
            else if (commit && head.dest == DEST_A) a_q <= head.result;

            if (reg_wr && reg_sel == DEST_X)      x_q <= reg_wdata;
            else if (commit && head.dest == DEST_X) x_q <= head.result;

            if (reg_wr && reg_sel == DEST_Y)      y_q <= reg_wdata;
            else if (commit && head.dest == DEST_Y) y_q <= head.result;

            if (plp_wr)      p_q <= plp_data | P_U_MASK;
            else if (commit) p_q <= merge_flags(p_q, head);
        end
    end

    assign wb_ready = !full;
    assign idle     = empty;
    assign x_out    = x_q;
    assign y_out    = y_q;

`ifdef WB_BYPASS_EN
    logic [7:0] acc_byp;
    logic [7:0] p_byp;

    // Walk the queue oldest to youngest so the youngest A result and the
    // latest flag values take effect.
    always_comb begin
        acc_byp = a_q;
        p_byp   = p_q;
        if (count != 2'd0) begin
            if (head.dest == DEST_A) acc_byp = head.result;
            p_byp = merge_flags(p_byp, head);
        end
        if (count == 2'd2) begin
            if (second.dest == DEST_A) acc_byp = second.result;
            p_byp = merge_flags(p_byp, second);
        end
    end

    assign acc_out = acc_byp;
    assign p_out   = p_byp;
`else
    wb_entry_t unused_second;
    assign unused_second = second;
    assign acc_out       = a_q;
    assign p_out         = p_q;
`endif

endmodule
